// File: rtl/lenet_pkg.sv
`default_nettype none
// =============================================================================
//  Module  : lenet_pkg
//  Brief   : Shared run-controller types and default configuration values.
//  Revision: 1.0
// =============================================================================
package lenet_pkg;

    localparam int c_DEF_NUM_STAGES = 7;
    localparam int c_DEF_CNT_W      = 21;
    localparam int c_DEF_TIMEOUT    = 260000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        START  = 3'd2,
        RUN    = 3'd3,
        NEXT   = 3'd4,
        FINISH = 3'd5,
        ERROR  = 3'd6
    } run_state_e;

    // Stage index width, never narrower than one bit.
    function automatic int stage_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lenet_sat_counter.sv
`default_nettype none
// =============================================================================
//  Module  : lenet_sat_counter
//  Brief   : Up-counter with synchronous clear that sticks at all-ones.
//  Revision: 1.0
// =============================================================================
module lenet_sat_counter #(
    parameter int CNT_W = 21
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_MAX = '1;

    logic [CNT_W-1:0] r_count_q;
    logic [CNT_W-1:0] w_count_d;

    // Clear has priority over counting.
    always_comb begin
        w_count_d = r_count_q;
        if (i_clear) begin
            w_count_d = '0;
        end else if (i_enable && (r_count_q != c_MAX)) begin
            w_count_d = r_count_q + c_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign o_count = r_count_q;

endmodule
`default_nettype wire

// File: rtl/lenet_run_ctrl.sv
`default_nettype none
// =============================================================================
//  Module  : lenet_run_ctrl
//  Brief   : Sequences load and per-layer compute phases of the accelerator,
//            with phase watchdog and cycle statistics.
//  Revision: 1.0
// =============================================================================
module lenet_run_ctrl
    import lenet_pkg::*;
#(
    parameter  int NUM_STAGES = c_DEF_NUM_STAGES,
    parameter  int CNT_W      = c_DEF_CNT_W,
    parameter  int TIMEOUT    = c_DEF_TIMEOUT,
    localparam int STAGE_W    = stage_width(NUM_STAGES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               clear_err,
    input  logic               load_done,
    input  logic               stage_done,
    output logic               re,
    output logic               wen,
    output logic               stage_start,
    output logic [STAGE_W-1:0] stage_idx,
    output logic               busy,
    output logic               done,
    output logic               timeout_err,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [CNT_W-1:0]   stage_cycles,
    output logic               stage_cycles_vld
);

    localparam logic [STAGE_W-1:0] c_LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
    localparam logic [STAGE_W-1:0] c_STAGE_ONE  = STAGE_W'(1);
    localparam logic [CNT_W-1:0]   c_WD_LIMIT   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   c_CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX    = '1;

    run_state_e         r_state_q;
    run_state_e         w_state_d;
    logic [STAGE_W-1:0] r_stage_idx_q;
    logic [STAGE_W-1:0] w_stage_idx_d;
    logic               r_timeout_err_q;
    logic               w_timeout_err_d;
    logic [CNT_W-1:0]   r_stage_cycles_q;
    logic [CNT_W-1:0]   w_stage_cycles_d;
    logic               r_stage_cycles_vld_q;
    logic               w_stage_cycles_vld_d;

    logic               w_busy;
    logic               w_run_clear;
    logic               w_wd_phase;
    logic               w_stage_phase;
    logic               w_wd_expired;
    logic [CNT_W-1:0]   w_stage_cnt;
    logic [CNT_W-1:0]   w_wd_cnt;

    assign w_busy        = (r_state_q != IDLE) && (r_state_q != ERROR);
    assign w_run_clear   = (r_state_q == IDLE) && start;
    assign w_wd_phase    = (r_state_q == LOAD) || (r_state_q == RUN);
    assign w_stage_phase = (r_state_q == START) || (r_state_q == RUN);
    // The current cycle is the TIMEOUT-th of the phase: no further cycle is allowed.
    assign w_wd_expired  = (w_wd_cnt >= c_WD_LIMIT);

    lenet_sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_run_clear),
        .i_enable (w_busy),
        .o_count  (cycle_cnt)
    );

    // Held at zero outside START/RUN so every stage starts counting from zero.
    lenet_sat_counter #(.CNT_W(CNT_W)) u_stage_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (!w_stage_phase),
        .i_enable (w_stage_phase),
        .o_count  (w_stage_cnt)
    );

    lenet_sat_counter #(.CNT_W(CNT_W)) u_wd_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (!w_wd_phase),
        .i_enable (w_wd_phase),
        .o_count  (w_wd_cnt)
    );

    always_comb begin
        w_state_d            = r_state_q;
        w_stage_idx_d        = r_stage_idx_q;
        w_timeout_err_d      = r_timeout_err_q;
        w_stage_cycles_d     = r_stage_cycles_q;
        w_stage_cycles_vld_d = 1'b0;

        case (r_state_q)
            IDLE: begin
                if (start) begin
                    w_state_d = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    w_state_d = IDLE;
                end else if (load_done) begin
                    w_state_d = START;
                end else if (w_wd_expired) begin
                    w_state_d       = ERROR;
                    w_timeout_err_d = 1'b1;
                end
            end
            START: begin
                w_state_d = abort ? IDLE : RUN;
            end
            RUN: begin
                if (abort) begin
                    w_state_d = IDLE;
                end else if (stage_done) begin
                    // This cycle is still part of the stage, hence the +1.
                    w_stage_cycles_vld_d = 1'b1;
                    w_stage_cycles_d     = (w_stage_cnt == c_CNT_MAX) ? c_CNT_MAX
                                                                      : w_stage_cnt + c_CNT_ONE;
                    w_state_d = (r_stage_idx_q == c_LAST_STAGE) ? FINISH : NEXT;
                end else if (w_wd_expired) begin
                    w_state_d       = ERROR;
                    w_timeout_err_d = 1'b1;
                end
            end
            NEXT: begin
                if (abort) begin
                    w_state_d = IDLE;
                end else begin
                    w_state_d     = START;
                    w_stage_idx_d = r_stage_idx_q + c_STAGE_ONE;
                end
            end
            FINISH: begin
                w_state_d = IDLE;
            end
            ERROR: begin
                if (clear_err) begin
                    w_state_d       = IDLE;
                    w_timeout_err_d = 1'b0;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase

        if (w_state_d == IDLE) begin
            w_stage_idx_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q            <= IDLE;
            r_stage_idx_q        <= '0;
            r_timeout_err_q      <= 1'b0;
            r_stage_cycles_q     <= '0;
            r_stage_cycles_vld_q <= 1'b0;
        end else begin
            r_state_q            <= w_state_d;
            r_stage_idx_q        <= w_stage_idx_d;
            r_timeout_err_q      <= w_timeout_err_d;
            r_stage_cycles_q     <= w_stage_cycles_d;
            r_stage_cycles_vld_q <= w_stage_cycles_vld_d;
        end
    end

    assign re               = (r_state_q == LOAD);
    assign wen              = (r_state_q == START) || (r_state_q == RUN) || (r_state_q == NEXT);
    assign stage_start      = (r_state_q == START);
    assign stage_idx        = r_stage_idx_q;
    assign busy             = w_busy;
    assign done             = (r_state_q == FINISH);
    assign timeout_err      = r_timeout_err_q;
    assign stage_cycles     = r_stage_cycles_q;
    assign stage_cycles_vld = r_stage_cycles_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_lenet_run_ctrl.sv
`default_nettype none
// =============================================================================
//  Module  : tb_lenet_run_ctrl
//  Brief   : Scoreboard bench for lenet_run_ctrl with randomized run timing.
//  Revision: 1.0
// =============================================================================
module tb_lenet_run_ctrl;

    localparam int c_STAGES    = 3;
    localparam int c_CNT_W     = 21;
    localparam int c_TIMEOUT   = 100;
    localparam int c_WAIT_MAX  = 400;
    localparam int c_B_CNT_W   = 4;
    localparam int c_B_TIMEOUT = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, start = 1'b0, abort = 1'b0, clear_err = 1'b0;
    logic load_done = 1'b0, stage_done = 1'b0;
    logic re, wen, stage_start, busy, done, timeout_err, stage_cycles_vld;
    logic [1:0] stage_idx;
    logic [c_CNT_W-1:0] cycle_cnt, stage_cycles;

    logic b_rst = 1'b1, b_start = 1'b0, b_abort = 1'b0, b_clear_err = 1'b0;
    logic b_load_done = 1'b0, b_stage_done = 1'b0;
    logic b_re, b_wen, b_stage_start, b_busy, b_done, b_timeout_err, b_stage_cycles_vld;
    logic [0:0] b_stage_idx;
    logic [c_B_CNT_W-1:0] b_cycle_cnt, b_stage_cycles;

    lenet_run_ctrl #(.NUM_STAGES(c_STAGES), .CNT_W(c_CNT_W), .TIMEOUT(c_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .clear_err(clear_err),
        .load_done(load_done), .stage_done(stage_done), .re(re), .wen(wen),
        .stage_start(stage_start), .stage_idx(stage_idx), .busy(busy), .done(done),
        .timeout_err(timeout_err), .cycle_cnt(cycle_cnt), .stage_cycles(stage_cycles),
        .stage_cycles_vld(stage_cycles_vld)
    );

    lenet_run_ctrl #(.NUM_STAGES(1), .CNT_W(c_B_CNT_W), .TIMEOUT(c_B_TIMEOUT)) dut_b (
        .clk(clk), .rst(b_rst), .start(b_start), .abort(b_abort), .clear_err(b_clear_err),
        .load_done(b_load_done), .stage_done(b_stage_done), .re(b_re), .wen(b_wen),
        .stage_start(b_stage_start), .stage_idx(b_stage_idx), .busy(b_busy), .done(b_done),
        .timeout_err(b_timeout_err), .cycle_cnt(b_cycle_cnt), .stage_cycles(b_stage_cycles),
        .stage_cycles_vld(b_stage_cycles_vld)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int     q_start[$];
    longint q_scyc[$];
    longint q_done[$];

    int dly[c_STAGES];
    bit prev_held = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: unexpected event (value %0d), expected none", name, act);
    endtask

    function automatic longint sat(input longint v, input int w);
        longint m;
        m = (longint'(1) << w) - 1;
        return (v > m) ? m : v;
    endfunction

    // Monitor: pops expectations whenever the DUT presents an event.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (stage_start) begin
                if (q_start.size() == 0) unexpected("stage_start", stage_idx);
                else check("stage_start_idx", stage_idx, q_start.pop_front());
            end
            if (stage_cycles_vld) begin
                if (q_scyc.size() == 0) unexpected("stage_cycles_vld", stage_cycles);
                else check("stage_cycles", stage_cycles, q_scyc.pop_front());
            end
            if (done) begin
                if (q_done.size() == 0) unexpected("done", cycle_cnt);
                else check("cycle_cnt_at_done", cycle_cnt, q_done.pop_front());
            end
        end
    end

    initial begin : global_limit
        #2000000;
        $display("FAIL global_limit: simulation did not finish in time");
        $fatal(1, "global time limit expired");
    end

    task automatic check_zero(input string tag);
        check({tag, "_re"}, re, 0);
        check({tag, "_wen"}, wen, 0);
        check({tag, "_stage_start"}, stage_start, 0);
        check({tag, "_stage_idx"}, stage_idx, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
        check({tag, "_cycle_cnt"}, cycle_cnt, 0);
        check({tag, "_stage_cycles"}, stage_cycles, 0);
        check({tag, "_stage_cycles_vld"}, stage_cycles_vld, 0);
    endtask

    task automatic wait_re(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!re && n < c_WAIT_MAX);
        if (!re) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_re: re low after %0d cycles, expected high", n);
        end
    endtask

    task automatic wait_ss(output bit ok);
        int n = 0;
        while (!stage_start && n < c_WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        ok = stage_start;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_stage_start: no pulse after %0d cycles, expected one", n);
        end
    endtask

    // One run: ld LOAD cycles, stage s done dly[s] cycles after its stage_start.
    task automatic do_run(input int ld, input int abort_stage, input int rst_stage, input bit hold_start);
        int     gap_exp;
        int     n;
        bit     ok;
        longint total;
        gap_exp   = prev_held ? 2 : 1;
        prev_held = hold_start;
        total     = ld + c_STAGES - 1;
        for (int s = 0; s < c_STAGES; s++) total += 1 + dly[s];

        q_start.push_back(0);
        start = 1'b1;
        wait_re(n);
        if (!re) return;
        check("start_to_load_gap", n, gap_exp);
        check("cycle_cnt_at_load0", cycle_cnt, 0);
        if (!hold_start) start = 1'b0;
        repeat (ld - 1) @(negedge clk);
        load_done = 1'b1;
        @(negedge clk);
        load_done = 1'b0;

        for (int s = 0; s < c_STAGES; s++) begin
            wait_ss(ok);
            if (!ok) return;
            if (s == rst_stage) begin
                repeat (3) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                check_zero("rst_in_run");
                rst = 1'b0;
                return;
            end
            repeat (dly[s]) @(negedge clk);
            check("stage_idx_in_run", stage_idx, s);
            check("wen_in_run", wen, 1);
            stage_done = 1'b1;
            if (s == abort_stage) begin
                abort = 1'b1;
                @(negedge clk);
                stage_done = 1'b0;
                abort      = 1'b0;
                check("abort_busy", busy, 0);
                check("abort_stage_idx", stage_idx, 0);
                check("abort_done", done, 0);
                check("abort_vld", stage_cycles_vld, 0);
                check("abort_timeout_err", timeout_err, 0);
                return;
            end
            q_scyc.push_back(sat(dly[s] + 1, c_CNT_W));
            if (s < c_STAGES - 1) q_start.push_back(s + 1);
            else q_done.push_back(sat(total, c_CNT_W));
            @(negedge clk);
            stage_done = 1'b0;
        end
        if (!hold_start) @(negedge clk);
    endtask

    task automatic rand_dly();
        for (int s = 0; s < c_STAGES; s++) dly[s] = int'($urandom_range(1, 15));
    endtask

    initial begin : main
        repeat (3) @(negedge clk);
        check_zero("reset");
        check("b_reset_busy", b_busy, 0);
        check("b_reset_cycle_cnt", b_cycle_cnt, 0);
        check("b_reset_stage_cycles", b_stage_cycles, 0);
        rst   = 1'b0;
        b_rst = 1'b0;
        @(negedge clk);

        for (int s = 0; s < c_STAGES; s++) dly[s] = 10;
        do_run(5, -1, -1, 1'b0);

        for (int r = 0; r < 8; r++) begin
            rand_dly();
            do_run(int'($urandom_range(1, 12)), -1, -1, 1'b0);
        end

        // Done inputs arriving on the last allowed watchdog cycle.
        dly[0] = 100; dly[1] = 1; dly[2] = 100;
        do_run(100, -1, -1, 1'b0);

        rand_dly();
        do_run(int'($urandom_range(1, 12)), -1, -1, 1'b1);
        rand_dly();
        do_run(int'($urandom_range(1, 12)), -1, -1, 1'b0);

        rand_dly();
        do_run(int'($urandom_range(1, 12)), 1, -1, 1'b0);

        // Load watchdog.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("wd_re_load0", re, 1);
        repeat (c_TIMEOUT - 1) @(negedge clk);
        check("wd_re_last_load", re, 1);
        check("wd_err_last_load", timeout_err, 0);
        @(negedge clk);
        check("wd_re_error", re, 0);
        check("wd_wen_error", wen, 0);
        check("wd_busy_error", busy, 0);
        check("wd_timeout_err", timeout_err, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("wd_start_ignored_re", re, 0);
        check("wd_err_sticky", timeout_err, 1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("wd_cleared", timeout_err, 0);
        check("wd_idle_busy", busy, 0);

        rand_dly();
        dly[2] = 12;
        do_run(int'($urandom_range(1, 12)), -1, 2, 1'b0);

        rand_dly();
        do_run(int'($urandom_range(1, 12)), -1, -1, 1'b0);

        // Narrow counters: stage ends on the last watchdog cycle, counters saturate.
        b_start = 1'b1;
        @(negedge clk);
        b_start     = 1'b0;
        b_load_done = 1'b1;
        @(negedge clk);
        b_load_done = 1'b0;
        check("b_stage_start", b_stage_start, 1);
        repeat (c_B_TIMEOUT) @(negedge clk);
        check("b_wen_last_run", b_wen, 1);
        b_stage_done = 1'b1;
        @(negedge clk);
        b_stage_done = 1'b0;
        check("b_done", b_done, 1);
        check("b_stage_cycles_vld", b_stage_cycles_vld, 1);
        check("b_stage_cycles_sat", b_stage_cycles, 15);
        check("b_cycle_cnt_sat", b_cycle_cnt, 15);
        check("b_no_timeout", b_timeout_err, 0);
        @(negedge clk);
        check("b_idle_busy", b_busy, 0);
        check("b_cycle_cnt_hold", b_cycle_cnt, 15);

        // Narrow counters: run watchdog fires one cycle later.
        b_start = 1'b1;
        @(negedge clk);
        b_start     = 1'b0;
        b_load_done = 1'b1;
        @(negedge clk);
        b_load_done = 1'b0;
        repeat (c_B_TIMEOUT) @(negedge clk);
        check("b_wd_wen_last", b_wen, 1);
        check("b_wd_err_last", b_timeout_err, 0);
        @(negedge clk);
        check("b_wd_err", b_timeout_err, 1);
        check("b_wd_wen_error", b_wen, 0);
        b_clear_err = 1'b1;
        @(negedge clk);
        b_clear_err = 1'b0;
        check("b_wd_cleared", b_timeout_err, 0);

        repeat (5) @(negedge clk);
        check("left_stage_start", q_start.size(), 0);
        check("left_stage_cycles", q_scyc.size(), 0);
        check("left_done", q_done.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
